// File: rtl/reg_writeback.sv
// reg_writeback: write-side front end of the 4-entry register group.
// Buffers execute-stage result writes in a small FIFO.
// Drains one write per cycle as a one-hot enable plus data.
// Publishes a per-register pending mask for read-after-write stalls.
module reg_writeback #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic [1:0]        rd,
    input  logic [DATA_W-1:0] d_in,
    input  logic              hold,
    output logic              ready,
    output logic [3:0]        reg_en,
    output logic [DATA_W-1:0] d_out,
    output logic              en_out,
    output logic [3:0]        pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // FIFO storage; the slot contents need no reset because valid gates them
    logic [1:0]        rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;

    // A full FIFO refuses new requests even when the head drains on the same edge
    assign ready = (count != CNT_W'(DEPTH));
    assign push  = en_in && ready;
    assign pop   = (count != '0) && !hold;

    // Capture the request payload at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= rd;
            data_mem[wr_ptr] <= d_in;
        end
    end

    // Pointer, occupancy and per-slot valid bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                wr_ptr         <= wr_ptr + PTR_W'(1);
                valid[wr_ptr]  <= 1'b1;
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                valid[rd_ptr]  <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port toward the register group; d_out holds when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_en <= '0;
            d_out  <= '0;
            en_out <= 1'b0;
        end else if (pop) begin
            reg_en <= 4'b0001 << rd_mem[rd_ptr];
            d_out  <= data_mem[rd_ptr];
            en_out <= 1'b1;
        end else begin
            reg_en <= '0;
            en_out <= 1'b0;
        end
    end

    // Pending mask: every queued destination plus the write being presented now
    always_comb begin
        pending = reg_en;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pending = pending | (4'b0001 << rd_mem[i]);
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scoreboard bench for reg_writeback.
// Accepted requests are queued as expected writes and retired when issued.
module tb_reg_writeback;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 2;

    typedef struct {
        logic [1:0]        r;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk;
    logic              rst;
    logic              en_in;
    logic [1:0]        rd;
    logic [DATA_W-1:0] d_in;
    logic              hold;
    logic              ready;
    logic [3:0]        reg_en;
    logic [DATA_W-1:0] d_out;
    logic              en_out;
    logic [3:0]        pending;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] last_d;
    int                checks;
    int                errors;

    reg_writeback #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en_in   (en_in),
        .rd      (rd),
        .d_in    (d_in),
        .hold    (hold),
        .ready   (ready),
        .reg_en  (reg_en),
        .d_out   (d_out),
        .en_out  (en_out),
        .pending (pending)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard bound on simulated time
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] r);
        logic [3:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Compare outputs against the scoreboard after an edge
    task automatic sampleOutputs(input bit expect_issue);
        wr_t        head;
        logic [3:0] exp_en;
        logic [3:0] exp_pend;
        exp_en = '0;
        if (expect_issue) begin
            head   = exp_q.pop_front();
            exp_en = onehot(head.r);
            last_d = head.d;
        end
        exp_pend = exp_en;
        foreach (exp_q[i]) exp_pend = exp_pend | onehot(exp_q[i].r);
        checkOutput("en_out", 32'(en_out), 32'(expect_issue));
        checkOutput("reg_en", 32'(reg_en), 32'(exp_en));
        checkOutput("d_out", 32'(d_out), 32'(last_d));
        checkOutput("pending", 32'(pending), 32'(exp_pend));
        checkOutput("en_out_vs_reg_en", 32'(en_out), 32'(reg_en != 4'b0000));
    endtask

    // One clock of stimulus: drive, predict, clock, then check
    task automatic applyStimulus(input logic e, input logic [1:0] r,
                                 input logic [DATA_W-1:0] d, input logic h);
        bit  accept;
        bit  will_pop;
        wr_t w;
        en_in = e;
        rd    = r;
        d_in  = d;
        hold  = h;
        checkOutput("ready", 32'(ready), 32'(exp_q.size() < DEPTH));
        accept   = e && (exp_q.size() < DEPTH);
        will_pop = (exp_q.size() != 0) && !h;
        @(posedge clk);
        if (accept) begin
            w.r = r;
            w.d = d;
            exp_q.push_back(w);
        end
        @(negedge clk);
        sampleOutputs(will_pop);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_d = '0;
        en_in  = 1'b0;
        rd     = '0;
        d_in   = '0;
        hold   = 1'b0;
        rst    = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        sampleOutputs(1'b0);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        rst = 1'b1;

        $display("[TB] single write");
        applyStimulus(1'b1, 2'd2, 16'hA5A5, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);

        $display("[TB] fill under hold, third push dropped");
        applyStimulus(1'b1, 2'd1, 16'h0011, 1'b1);
        applyStimulus(1'b1, 2'd3, 16'h0033, 1'b1);
        checkOutput("full_pending", 32'(pending), 32'(4'b1010));
        applyStimulus(1'b1, 2'd0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);

        $display("[TB] streaming one write per cycle");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), 16'h1000 + 16'(i), 1'b0);
        end
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);

        $display("[TB] full with simultaneous pop");
        applyStimulus(1'b1, 2'd0, 16'h0B0B, 1'b1);
        applyStimulus(1'b1, 2'd1, 16'h0C0C, 1'b1);
        applyStimulus(1'b1, 2'd2, 16'h0D0D, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b1);
        checkOutput("one_left_pending", 32'(pending), 32'(4'b0010));
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);

        $display("[TB] same-register ordering");
        applyStimulus(1'b1, 2'd1, 16'h0001, 1'b0);
        applyStimulus(1'b1, 2'd1, 16'h0002, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 2'd0, 16'h1111, 1'b1);
        applyStimulus(1'b1, 2'd3, 16'h2222, 1'b1);
        en_in = 1'b0;
        hold  = 1'b0;
        #2 rst = 1'b0;
        exp_q.delete();
        last_d = '0;
        #1;
        sampleOutputs(1'b0);
        checkOutput("midreset_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
